// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps a combinational function through all inputs and checks it against an expected table.
// Optional TTS_STOP_ON_FAIL_EN ends the sweep on the first mismatching entry.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   result,
  output logic [N_IN:0]        mismatch_count,
  output logic                 first_fail_valid,
  output logic [N_IN-1:0]      first_fail_idx
);
  localparam int W = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(W-1);
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_DONE} state_t;
  state_t state;
  logic [3:0] settle;
  logic [W-1:0] exp_q;
  logic mis, last;
  assign mis = dut_f != exp_q[dut_in];
`ifdef TTS_STOP_ON_FAIL_EN
  assign last = (dut_in == LAST) || mis;
`else
  assign last = dut_in == LAST;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      settle <= '0;
      exp_q <= '0;
      dut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      result <= '0;
      mismatch_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start && !abort) begin
          exp_q <= expected;
          result <= '0;
          mismatch_count <= '0;
          first_fail_valid <= 1'b0;
          first_fail_idx <= '0;
          pass <= 1'b0;
          dut_in <= '0;
          settle <= 4'(SETTLE_CYCLES);
          busy <= 1'b1;
          state <= ST_APPLY;
        end
        ST_APPLY: if (abort) begin
          busy <= 1'b0;
          pass <= 1'b0;
          state <= ST_IDLE;
        end else if (settle != 4'd0) begin
          settle <= settle - 4'd1;
        end else begin
          result[dut_in] <= dut_f;
          if (mis) begin
            mismatch_count <= mismatch_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_idx <= dut_in;
              first_fail_valid <= 1'b1;
            end
          end
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= !mis && mismatch_count == '0;
            state <= ST_DONE;
          end else begin
            dut_in <= dut_in + 1'b1;
            settle <= 4'(SETTLE_CYCLES);
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and random sweeps checked against a table-level reference model.
module tb_truth_table_sweeper;
  logic clk = 0, rst_n = 0;
  logic start0 = 0, abort0 = 0, start_t = 0;
  logic [15:0] expected0 = '0, fn_table = '0;
  logic [3:0] dut_in0, dut_in1, dut_in2, ffi0, ffi1, ffi2;
  logic busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1, busy2, done2, pass2, ffv2;
  logic [15:0] result0, result1, result2;
  logic [4:0] mc0, mc1, mc2;
  logic dut_f0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign dut_f0 = fn_table[dut_in0];

  truth_table_sweeper u0 (.clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(expected0),
    .dut_in(dut_in0), .dut_f(dut_f0), .busy(busy0), .done(done0), .pass(pass0), .result(result0),
    .mismatch_count(mc0), .first_fail_valid(ffv0), .first_fail_idx(ffi0));
  truth_table_sweeper #(.SETTLE_CYCLES(0)) u1 (.clk(clk), .rst_n(rst_n), .start(start_t), .abort(1'b0),
    .expected(16'hFFFF), .dut_in(dut_in1), .dut_f(1'b1), .busy(busy1), .done(done1), .pass(pass1),
    .result(result1), .mismatch_count(mc1), .first_fail_valid(ffv1), .first_fail_idx(ffi1));
  truth_table_sweeper #(.SETTLE_CYCLES(3)) u2 (.clk(clk), .rst_n(rst_n), .start(start_t), .abort(1'b0),
    .expected(16'hFFFF), .dut_in(dut_in2), .dut_f(1'b1), .busy(busy2), .done(done2), .pass(pass2),
    .result(result2), .mismatch_count(mc2), .first_fail_valid(ffv2), .first_fail_idx(ffi2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Reference: whole-table view of what a sweep should report, with the done edge counted from the start edge.
  task automatic model(input logic [15:0] fn, input logic [15:0] ex, output logic [15:0] res, output int cnt,
                       output int fi, output bit fv, output bit p, output int de);
    logic [15:0] diff;
    diff = fn ^ ex;
    fi = 0;
    fv = diff != 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) fi = i;
    res = fn;
    cnt = $countones(diff);
    de = 32;
`ifdef TTS_STOP_ON_FAIL_EN
    if (fv) begin
      res = fn & 16'((32'd2 << fi) - 1);
      cnt = 1;
      de = 2 * (fi + 1);
    end
`endif
    p = !fv;
  endtask

  task automatic run_sweep(input logic [15:0] fn, input logic [15:0] ex, input string tag);
    logic [15:0] r;
    int c, fi, de, got, bc;
    bit fv, p, seq_ok;
    model(fn, ex, r, c, fi, fv, p, de);
    got = -1;
    seq_ok = 1;
    fn_table = fn;
    expected0 = ex;
    @(negedge clk) start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    expected0 = 16'($urandom);
    bc = busy0 ? 1 : 0;
    if (dut_in0 !== 4'd0) seq_ok = 0;
    for (int e = 1; e <= 100 && got < 0; e++) begin
      @(posedge clk);
      #1;
      if (busy0) begin
        bc++;
        if (dut_in0 !== 4'(e / 2)) seq_ok = 0;
      end
      if (done0) got = e;
    end
    check({tag, "_done_cycle"}, 32'(got + 1), 32'(de + 1));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(de));
    check({tag, "_dut_in_seq"}, 32'(seq_ok), 32'd1);
    check({tag, "_result"}, 32'(result0), 32'(r));
    check({tag, "_mismatch"}, 32'(mc0), 32'(c));
    check({tag, "_ff_valid"}, 32'(ffv0), 32'(fv));
    check({tag, "_ff_idx"}, 32'(ffi0), 32'(fv ? fi : 0));
    check({tag, "_pass"}, 32'(pass0), 32'(p));
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, 32'(done0), 32'd0);
    check({tag, "_hold"}, {15'd0, pass0, result0}, {15'd0, p, r});
  endtask

  initial begin
    logic [15:0] fn_ok, fn, msk;
    int zeros[6] = '{0, 1, 5, 8, 9, 13};
    int d1, d2, b1;
    bit st_ok;
    fn_ok = 16'hFFFF;
    foreach (zeros[i]) fn_ok[zeros[i]] = 1'b0;
    #12;
    check("reset_result", 32'(result0), 32'd0);
    check("reset_misc", {15'd0, dut_in0, busy0, done0, pass0, mc0, ffv0, ffi0}, 32'd0);
    @(negedge clk) rst_n = 1;

    run_sweep(fn_ok, 16'hDCDC, "good");
    run_sweep(fn_ok | 16'h0020, 16'hDCDC, "bit5");
    for (int k = 0; k < 6; k++) begin
      fn = 16'($urandom);
      case ($urandom_range(0, 2))
        0: msk = 16'd0;
        1: msk = 16'd1 << $urandom_range(0, 15);
        default: msk = 16'($urandom);
      endcase
      run_sweep(fn, fn ^ msk, $sformatf("rand%0d", k));
    end

    // Start mid-sweep is ignored; abort at cycle 10 drops to idle with partial results.
    fn = 16'($urandom) | 16'h0001;
    fn_table = fn;
    expected0 = fn;
    @(negedge clk) start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    repeat (4) @(posedge clk);
    #1 start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_pre_dut_in", 32'(dut_in0), 32'd4);
    abort0 = 1;
    @(posedge clk);
    #1 abort0 = 0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_pass", 32'(pass0), 32'd0);
    check("abort_result", 32'(result0), 32'(fn & 16'h000F));
    check("abort_mismatch", 32'(mc0), 32'd0);
    st_ok = 1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) st_ok = 0;
    end
    check("abort_no_done", 32'(st_ok), 32'd1);

    // Reset mid-sweep at cycle 20.
    fn_table = fn_ok;
    expected0 = 16'h1234;
    @(negedge clk) start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    repeat (19) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_result", 32'(result0), 32'd0);
    check("midrst_misc", {15'd0, dut_in0, busy0, done0, pass0, mc0, ffv0, ffi0}, 32'd0);
    @(negedge clk) rst_n = 1;

    // Start and abort together in idle.
    @(negedge clk) begin start0 = 1; abort0 = 1; end
    @(posedge clk);
    #1 begin start0 = 0; abort0 = 0; end
    st_ok = 1;
    repeat (4) begin
      if (busy0) st_ok = 0;
      @(posedge clk);
      #1;
    end
    check("start_abort_idle", 32'(st_ok), 32'd1);

    // Settle-cycle variants run side by side.
    d1 = -1;
    d2 = -1;
    st_ok = 1;
    @(negedge clk) start_t = 1;
    @(posedge clk);
    #1 start_t = 0;
    b1 = busy1 ? 1 : 0;
    if (dut_in2 !== 4'd0) st_ok = 0;
    for (int e = 1; e <= 100 && d2 < 0; e++) begin
      @(posedge clk);
      #1;
      if (busy1) b1++;
      if (busy2 && dut_in2 !== 4'(e / 4)) st_ok = 0;
      if (done1 && d1 < 0) d1 = e;
      if (done2) d2 = e;
    end
    check("s0_done_cycle", 32'(d1 + 1), 32'd17);
    check("s0_busy_cycles", 32'(b1), 32'd16);
    check("s0_pass_result", {15'd0, pass1, result1}, {15'd1, 16'hFFFF});
    check("s3_done_cycle", 32'(d2 + 1), 32'd65);
    check("s3_dut_in_stable", 32'(st_ok), 32'd1);
    check("s3_pass_result", {15'd0, pass2, result2}, {15'd1, 16'hFFFF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
